// File: rtl/nmea_pkg.sv
// Shared constants, FSM state type and hex helpers for the NMEA sentence checker.
package nmea_pkg;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    localparam int unsigned TYPE_CHARS = 5;
    localparam int unsigned TYPE_W     = 8 * TYPE_CHARS;
    localparam int unsigned UTC_DIGITS = 6;
    localparam int unsigned UTC_W      = 4 * UTC_DIGITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TYPE,
        S_FIELD1,
        S_BODY,
        S_CSUM_HI,
        S_CSUM_LO,
        S_WAIT_CR,
        S_WAIT_LF
    } state_t;

    // Uppercase hex digit only: '0'-'9', 'A'-'F'.
    function automatic logic is_hex(input logic [7:0] ch);
        return ((ch >= 8'h30) && (ch <= 8'h39)) || ((ch >= 8'h41) && (ch <= 8'h46));
    endfunction

    // Caller guarantees is_hex(ch).
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] ch);
        return (ch <= 8'h39) ? 4'(ch - 8'h30) : 4'(ch - 8'h37);
    endfunction

endpackage

// File: rtl/nmea_char_class.sv
// Combinational byte classifier used by the sentence FSM.
module nmea_char_class
    import nmea_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic       is_hex,
    output logic       is_printable,
    output logic       is_delim
);

    // Classify the byte into the character groups the framer cares about.
    always_comb begin
        is_digit     = (ch >= 8'h30) && (ch <= 8'h39);
        is_hex       = nmea_pkg::is_hex(ch);
        is_printable = (ch >= 8'h20) && (ch <= 8'h7E);
        is_delim     = (ch == CH_COMMA) || (ch == CH_STAR);
    end

endmodule

// File: rtl/nmea_sentence_checker.sv
// Frames NMEA-0183 sentences, verifies the XOR checksum, captures the
// talker/type field and the UTC time field, and counts good/bad sentences.
module nmea_sentence_checker
    import nmea_pkg::*;
#(
    parameter int unsigned MAX_LEN = 82,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_ready,
    input  logic              rx_endofpacket,
    output logic              sent_valid,
    output logic              sent_error,
    output logic [TYPE_W-1:0] sent_type,
    output logic [UTC_W-1:0]  utc_bcd,
    output logic              utc_ok,
    output logic [CNT_W-1:0]  valid_count,
    output logic [CNT_W-1:0]  error_count
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    state_t              state, state_n;
    logic [7:0]          csum, csum_n;
    logic [LEN_W-1:0]    len, len_n;
    logic [TYPE_W-1:0]   type_sr, type_n;
    logic [UTC_W-1:0]    bcd_sr, bcd_n;
    logic [2:0]          ndig, ndig_n;
    logic [3:0]          csum_hi, hi_n;
    logic                byte_err, err, done;

    logic c_digit, c_hex, c_print, c_delim;

    nmea_char_class u_class (
        .ch           (rx_data),
        .is_digit     (c_digit),
        .is_hex       (c_hex),
        .is_printable (c_print),
        .is_delim     (c_delim)
    );

    // FSM state and per-sentence working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            csum    <= '0;
            len     <= '0;
            type_sr <= '0;
            bcd_sr  <= '0;
            ndig    <= '0;
            csum_hi <= '0;
        end else begin
            state   <= state_n;
            csum    <= csum_n;
            len     <= len_n;
            type_sr <= type_n;
            bcd_sr  <= bcd_n;
            ndig    <= ndig_n;
            csum_hi <= hi_n;
        end
    end

    // Next-state logic: byte handling first, then a line-idle abort on top.
    always_comb begin
        state_n  = state;
        csum_n   = csum;
        len_n    = len;
        type_n   = type_sr;
        bcd_n    = bcd_sr;
        ndig_n   = ndig;
        hi_n     = csum_hi;
        byte_err = 1'b0;
        done     = 1'b0;
        err      = 1'b0;

        if (rx_data_ready) begin
            if (rx_data == CH_DOLLAR) begin
                // A '$' always starts a fresh sentence; mid-sentence it also flags an error.
                byte_err = (state != S_IDLE);
                state_n  = S_TYPE;
                csum_n   = '0;
                len_n    = LEN_W'(1);
                type_n   = '0;
                bcd_n    = '0;
                ndig_n   = '0;
            end else if (state == S_IDLE) begin
                // Noise between sentences is ignored.
            end else if (len == LEN_W'(MAX_LEN)) begin
                byte_err = 1'b1;
            end else begin
                len_n = len + LEN_W'(1);
                case (state)
                    S_TYPE: begin
                        if (len < LEN_W'(TYPE_CHARS + 1)) begin
                            if (c_print && !c_delim) begin
                                type_n = {type_sr[TYPE_W-9:0], rx_data};
                                csum_n = csum ^ rx_data;
                            end else begin
                                byte_err = 1'b1;
                            end
                        end else if (rx_data == CH_COMMA) begin
                            csum_n  = csum ^ rx_data;
                            state_n = S_FIELD1;
                        end else begin
                            byte_err = 1'b1;
                        end
                    end
                    S_FIELD1: begin
                        if (c_digit) begin
                            bcd_n  = {bcd_sr[UTC_W-5:0], rx_data[3:0]};
                            ndig_n = ndig + 3'd1;
                            csum_n = csum ^ rx_data;
                            if (ndig == 3'(UTC_DIGITS - 1)) begin
                                state_n = S_BODY;
                            end
                        end else if (rx_data == CH_COMMA) begin
                            csum_n  = csum ^ rx_data;
                            state_n = S_BODY;
                        end else if (rx_data == CH_STAR) begin
                            state_n = S_CSUM_HI;
                        end else begin
                            byte_err = 1'b1;
                        end
                    end
                    S_BODY: begin
                        if (rx_data == CH_STAR) begin
                            state_n = S_CSUM_HI;
                        end else if (c_print) begin
                            csum_n = csum ^ rx_data;
                        end else begin
                            byte_err = 1'b1;
                        end
                    end
                    S_CSUM_HI: begin
                        if (c_hex) begin
                            hi_n    = hex_to_nibble(rx_data);
                            state_n = S_CSUM_LO;
                        end else begin
                            byte_err = 1'b1;
                        end
                    end
                    S_CSUM_LO: begin
                        if (c_hex && ({csum_hi, hex_to_nibble(rx_data)} == csum)) begin
                            state_n = S_WAIT_CR;
                        end else begin
                            byte_err = 1'b1;
                        end
                    end
                    S_WAIT_CR: begin
                        if (rx_data == CH_CR) begin
                            state_n = S_WAIT_LF;
                        end else begin
                            byte_err = 1'b1;
                        end
                    end
                    S_WAIT_LF: begin
                        if (rx_data == CH_LF) begin
                            done    = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            byte_err = 1'b1;
                        end
                    end
                    default: byte_err = 1'b1;
                endcase
            end
            if (byte_err && (rx_data != CH_DOLLAR)) begin
                state_n = S_IDLE;
            end
        end

        err = byte_err;
        if (rx_endofpacket && (state_n != S_IDLE)) begin
            err     = 1'b1;
            state_n = S_IDLE;
        end
    end

    // Result pulses, captured fields and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_valid  <= 1'b0;
            sent_error  <= 1'b0;
            sent_type   <= '0;
            utc_bcd     <= '0;
            utc_ok      <= 1'b0;
            valid_count <= '0;
            error_count <= '0;
        end else begin
            sent_valid <= done;
            sent_error <= err;
            if (done) begin
                sent_type   <= type_sr;
                utc_bcd     <= bcd_sr;
                utc_ok      <= (ndig == 3'(UTC_DIGITS));
                valid_count <= valid_count + CNT_W'(1);
            end
            if (err) begin
                error_count <= error_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nmea_sentence_checker.sv
// Self-checking bench for nmea_sentence_checker: a sentence-level model judges
// each growing sentence prefix as a whole; outputs are compared every cycle.
module tb_nmea_sentence_checker;

    localparam int MAX_LEN = 82;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_ready = 1'b0;
    logic        rx_endofpacket = 1'b0;
    logic        sent_valid, sent_error, utc_ok;
    logic [39:0] sent_type;
    logic [23:0] utc_bcd;
    logic [15:0] valid_count, error_count;

    int total = 0;
    int bad = 0;

    nmea_sentence_checker #(.MAX_LEN(82), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .rx_endofpacket (rx_endofpacket),
        .sent_valid     (sent_valid),
        .sent_error     (sent_error),
        .sent_type      (sent_type),
        .utc_bcd        (utc_bcd),
        .utc_ok         (utc_ok),
        .valid_count    (valid_count),
        .error_count    (error_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  cur[$];
    bit          m_active = 0;
    logic        exp_valid = 0, exp_err = 0, exp_ok = 0;
    bit          utc_care = 1;
    logic [39:0] exp_type = '0;
    logic [23:0] exp_utc = '0;
    int unsigned exp_vc = 0, exp_ec = 0;

    function automatic bit m_print(input logic [7:0] c);
        return c >= 8'd32 && c <= 8'd126;
    endfunction
    function automatic bit m_dig(input logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction
    function automatic bit m_hex(input logic [7:0] c);
        return m_dig(c) || (c >= "A" && c <= "F");
    endfunction
    function automatic int m_val(input logic [7:0] c);
        return m_dig(c) ? int'(c) - 48 : int'(c) - 55;
    endfunction

    // 0: prefix still acceptable, 1: prefix is broken at its last byte, 2: sentence complete
    function automatic int judge(input logic [7:0] q[$]);
        int n = q.size();
        int i, nd, star, x;
        if (n > MAX_LEN) return 1;
        for (int k = 1; k < n && k <= 5; k++)
            if (!m_print(q[k]) || q[k] == "," || q[k] == "*") return 1;
        if (n > 6 && q[6] != ",") return 1;
        i = 7; nd = 0; star = -1;
        while (i < n && nd < 6) begin
            if (m_dig(q[i])) begin nd++; i++; end
            else if (q[i] == ",") begin i++; break; end
            else if (q[i] == "*") begin star = i; break; end
            else return 1;
        end
        while (star < 0 && i < n) begin
            if (q[i] == "*") star = i;
            else if (!m_print(q[i])) return 1;
            i++;
        end
        if (star < 0) return 0;
        x = 0;
        for (int k = 1; k < star; k++) x = x ^ int'(q[k]);
        if (n > star + 1 && !m_hex(q[star+1])) return 1;
        if (n > star + 2) begin
            if (!m_hex(q[star+2])) return 1;
            if (m_val(q[star+1]) * 16 + m_val(q[star+2]) != x) return 1;
        end
        if (n > star + 3 && q[star+3] != 8'h0D) return 1;
        if (n > star + 4) return (q[star+4] == 8'h0A) ? 2 : 1;
        return 0;
    endfunction

    initial forever begin
        int r, nd, k;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cur.delete(); m_active = 0; exp_valid = 0; exp_err = 0; exp_ok = 0;
            exp_type = '0; exp_utc = '0; exp_vc = 0; exp_ec = 0; utc_care = 1;
        end else begin
            exp_valid = 0; exp_err = 0;
            if (rx_data_ready) begin
                if (rx_data == "$") begin
                    if (m_active) exp_err = 1;
                    m_active = 1; cur.delete(); cur.push_back(rx_data);
                end else if (m_active) begin
                    cur.push_back(rx_data);
                    r = judge(cur);
                    if (r == 1) begin
                        exp_err = 1; m_active = 0;
                    end else if (r == 2) begin
                        exp_valid = 1; m_active = 0;
                        for (k = 1; k <= 5; k++) exp_type = {exp_type[31:0], cur[k]};
                        nd = 0; exp_utc = '0; k = 7;
                        while (k < cur.size() && nd < 6 && m_dig(cur[k])) begin
                            exp_utc = {exp_utc[19:0], cur[k][3:0]}; nd++; k++;
                        end
                        exp_ok = (nd == 6); utc_care = (nd == 6);
                    end
                end
            end
            if (rx_endofpacket && m_active) begin exp_err = 1; m_active = 0; end
            if (exp_valid) exp_vc++;
            if (exp_err) exp_ec++;
        end
    end

    // Per-cycle comparison, away from the active edge.
    int obs_valid = 0, obs_err = 0;
    initial forever begin
        @(negedge clk);
        chk("sent_valid", 64'(sent_valid), 64'(exp_valid));
        chk("sent_error", 64'(sent_error), 64'(exp_err));
        chk("sent_type", 64'(sent_type), 64'(exp_type));
        chk("utc_ok", 64'(utc_ok), 64'(exp_ok));
        if (utc_care) chk("utc_bcd", 64'(utc_bcd), 64'(exp_utc));
        chk("valid_count", 64'(valid_count), 64'(exp_vc[15:0]));
        chk("error_count", 64'(error_count), 64'(exp_ec[15:0]));
        if (sent_valid) obs_valid++;
        if (sent_error) obs_err++;
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
    endtask
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask
    task automatic send_line(input string s);
        send_str(s); send_byte(8'h0D); send_byte(8'h0A);
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    string gga = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47";
    string gga_bad = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48";

    initial begin
        int ov, oe;
        #1 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        chk("rst_valid_count", 64'(valid_count), 0);
        chk("rst_error_count", 64'(error_count), 0);
        chk("rst_sent_type", 64'(sent_type), 0);
        chk("rst_utc_bcd", 64'(utc_bcd), 0);
        chk("rst_utc_ok", 64'(utc_ok), 0);

        // good GGA sentence
        send_line(gga);
        chk("gga_valid_pulse", 64'(sent_valid), 1);
        chk("gga_type", 64'(sent_type), 64'h47_50_47_47_41);
        chk("gga_utc", 64'(utc_bcd), 64'h123519);
        chk("gga_utc_ok", 64'(utc_ok), 1);
        chk("gga_vc", 64'(valid_count), 1);
        chk("model_vc", 64'(exp_vc), 1);
        idle(2);

        // checksum mismatch: error right after the '8'
        send_str(gga_bad);
        chk("bad_csum_pulse", 64'(sent_error), 1);
        chk("bad_csum_ec", 64'(error_count), 1);
        chk("bad_csum_type_held", 64'(sent_type), 64'h47_50_47_47_41);
        chk("bad_csum_utc_held", 64'(utc_bcd), 64'h123519);
        send_byte(8'h0D); send_byte(8'h0A);
        idle(2);

        // empty first field
        send_line("$GPGSV,,1,1*79");
        chk("gsv_valid_pulse", 64'(sent_valid), 1);
        chk("gsv_type", 64'(sent_type), 64'h47_50_47_53_56);
        chk("gsv_utc_ok", 64'(utc_ok), 0);
        chk("gsv_vc", 64'(valid_count), 2);
        idle(2);

        // truncation by line idle
        send_str("$GPRMC,0918");
        rx_endofpacket = 1'b1; idle(1); rx_endofpacket = 1'b0;
        chk("trunc_pulse", 64'(sent_error), 1);
        chk("trunc_ec", 64'(error_count), 2);
        send_line(gga);
        chk("after_trunc_vc", 64'(valid_count), 3);
        idle(2);

        // restart on a second '$'
        ov = obs_valid; oe = obs_err;
        send_str("$GPG");
        send_line(gga);
        idle(2);
        chk("restart_err_pulses", 64'(obs_err - oe), 1);
        chk("restart_valid_pulses", 64'(obs_valid - ov), 1);
        chk("restart_ec", 64'(error_count), 3);
        chk("restart_vc", 64'(valid_count), 4);

        // line idle in the same cycle as the closing LF: completion wins
        send_str(gga); send_byte(8'h0D);
        rx_endofpacket = 1'b1; send_byte(8'h0A); rx_endofpacket = 1'b0;
        chk("eop_lf_valid", 64'(sent_valid), 1);
        chk("eop_lf_noerr", 64'(sent_error), 0);
        chk("eop_lf_ec", 64'(error_count), 3);
        idle(2);

        // overlength: 82 bytes acceptable, byte 83 fails
        send_str("$GPGGA,,");
        for (int i = 0; i < 74; i++) send_byte("A");
        chk("len82_noerr", 64'(sent_error), 0);
        chk("len82_ec", 64'(error_count), 3);
        send_byte("A");
        chk("len83_pulse", 64'(sent_error), 1);
        chk("len83_ec", 64'(error_count), 4);
        idle(2);

        // reset mid-sentence
        send_str("$GPGGA,1235");
        rst_n = 1'b0;
        #2;
        chk("midrst_vc", 64'(valid_count), 0);
        chk("midrst_ec", 64'(error_count), 0);
        chk("midrst_type", 64'(sent_type), 0);
        chk("midrst_utc", 64'(utc_bcd), 0);
        chk("midrst_pulses", 64'({sent_valid, sent_error, utc_ok}), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_line(gga);
        chk("post_rst_valid", 64'(sent_valid), 1);
        chk("post_rst_vc", 64'(valid_count), 1);
        chk("post_rst_ec", 64'(error_count), 0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
